m_fft_load_ctrl: RTL and testbench
==================================

# m_fft_load_ctrl

Frame-load sequencer for the 32-point DIT FFT front end. Accepts a stream of time-domain samples over a valid/ready handshake and writes them into the 32-entry register file through its single write port, in bit-reversed address order so the butterfly stages read natural-order outputs. Once the register file's parallel outputs reflect the complete frame, it pulses `fft_start`. It then holds off further input until the FFT core returns `fft_done`.

## Interface
- `ADDR_WIDTH`, 5: register-file address width; frame length is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 16: sample width.
- `BITREV`, 1: 1 = write sample n to address bitrev(n); 0 = write to address n.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in DATA_WIDTH: input sample.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: controller can accept a sample.
- `ram_addr` out ADDR_WIDTH: register-file write address (registered).
- `ram_data` out DATA_WIDTH: register-file write data (registered).
- `ram_we` out 1: register-file write enable (registered).
- `fft_start` out 1: one-cycle pulse meaning the register-file outputs hold a complete frame.
- `fft_done` in 1: one-cycle pulse from the FFT core meaning the frame has been consumed.
- `busy` out 1: high in every state except LOAD.
- `frame_cnt` out 8: count of frames started; wraps 255→0.

## Operation
- States: LOAD, FLUSH, SETTLE, START, BUSY. Reset state is LOAD.
- `s_ready` is combinational, equal to (state == LOAD).
- Sample counter `cnt` is ADDR_WIDTH bits, 0 after reset.
- LOAD:
  - Handshake = `s_valid` && `s_ready`.
  - On each handshake: `ram_we`<=1, `ram_data`<=`s_data`, `ram_addr`<=bitrev(`cnt`) (or `cnt` if BITREV=0), `cnt`<=`cnt`+1.
  - With no handshake, `ram_we`<=0.
  - A handshake with `cnt`==2^ADDR_WIDTH-1 is the last sample: `cnt` wraps to 0 and the state goes to FLUSH.
  - `s_valid` gaps of any length are allowed. Partial frames simply wait.
- FLUSH: `ram_we`<=0 (the final write commits on this edge); goes to SETTLE.
- SETTLE: one wait cycle while the register-file output registers capture the final write; `fft_start`<=1; goes to START.
- START: `fft_start`<=0, `frame_cnt`<=`frame_cnt`+1; goes to BUSY.
- BUSY: waits for `fft_done`=1, then goes to LOAD. `fft_done` in any other state is ignored.
- Bit-reverse for ADDR_WIDTH=5: address bit i = `cnt` bit (4−i), e.g. 1→16, 3→24, 31→31.
- `ram_addr` and `ram_data` hold their last values when `ram_we`=0.
- Reset mid-frame:
  - State goes to LOAD and `cnt` to 0; the partial frame is discarded.
  - Register-file contents are not cleared; the next frame overwrites all entries.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `fft_start`=0, `frame_cnt`=0, `busy`=0. `s_ready`=1 in the first cycle after `rst` deasserts.
- Sample accepted at edge E: `ram_we`/`ram_addr`/`ram_data` are valid from E to E+1, and the register-file write occurs at E+1.
- Last sample accepted at edge E0:
  - E1: mem updated, state FLUSH→SETTLE.
  - E2: register-file outputs valid, `fft_start` rises.
  - E3: `fft_start` falls, `frame_cnt` increments, state BUSY.
- `fft_start` is exactly 1 cycle wide. `s_ready`=0 from E0+1 until the edge after `fft_done` is sampled.
- Minimum frame period is 32 + 4 cycles, with `fft_done` arriving in the first BUSY cycle.
- Back-to-back: `s_ready` is 1 in the cycle after `fft_done` is sampled in BUSY.

## Test plan
- **Reset, then continuous stream:** reset, then `s_valid`=1 continuously with `s_data`=n for n=0..31 → `ram_addr` sequence 0,16,8,24,4,…,31. `fft_start` pulses 2 cycles after the last `ram_we`. Register-file output dataK = bitrev(K).
- **Gapped input:** `s_valid` toggled randomly over 32 samples → identical write order and values. `cnt` advances only on handshakes. One `fft_start` pulse.
- **BUSY back-pressure:** after `fft_start`, hold `s_valid`=1 for 20 cycles with no `fft_done` → `s_ready`=0 and `ram_we`=0 throughout. Pulse `fft_done` → `s_ready`=1 next cycle.
- **Spurious done:** `fft_done` pulse during LOAD at `cnt`=10 → ignored, `cnt` continues to 11 on the next handshake.
- **Reset mid-frame:** `rst` at `cnt`=17 → next frame writes start at address 0. `fft_start` fires only after 32 fresh samples.
- **Natural order and wrap:** BITREV=0 → addresses 0..31 in order. Run 256 frames → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/m_fft_load_ctrl_if.sv
// Sample stream handshake into the FFT frame-load sequencer.
// The master drives samples; the slave (load controller) answers with s_ready.
interface m_fft_load_ctrl_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/m_fft_load_ctrl.sv
// Frame-load sequencer: writes one frame of samples into the FFT register file
// in (optionally) bit-reversed order, pulses fft_start, then waits for fft_done.
module m_fft_load_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int BITREV     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    m_fft_load_ctrl_if.slave      s_if,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic                  busy,
    output logic [7:0]            frame_cnt
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FLUSH,
        S_SETTLE,
        S_START,
        S_BUSY
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic                  r_ram_we;
    logic                  r_fft_start;
    logic [7:0]            r_frame_cnt;

    logic                  w_s_ready;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_wr_addr;

    assign w_s_ready = (r_state == S_LOAD);
    assign w_hs      = s_if.s_valid && w_s_ready;

    // Bit-reversed write order lets the butterfly stages read outputs in natural order.
    generate
        if (BITREV != 0) begin : g_rev
            for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_bit
                assign w_wr_addr[gi] = r_cnt[ADDR_WIDTH-1-gi];
            end
        end else begin : g_nat
            assign w_wr_addr = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_we    <= 1'b0;
            r_fft_start <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_hs) begin
                        r_ram_we   <= 1'b1;
                        r_ram_data <= s_if.s_data;
                        r_ram_addr <= w_wr_addr;
                        r_cnt      <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_FLUSH;
                        end
                    end else begin
                        r_ram_we <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // The last sample's write lands in the register file on this edge.
                    r_ram_we <= 1'b0;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_fft_start <= 1'b1;
                    r_state     <= S_START;
                end
                S_START: begin
                    r_fft_start <= 1'b0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    r_state     <= S_BUSY;
                end
                S_BUSY: begin
                    if (fft_done) begin
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign s_if.s_ready = w_s_ready;
    assign busy         = !w_s_ready;
    assign ram_addr     = r_ram_addr;
    assign ram_data     = r_ram_data;
    assign ram_we       = r_ram_we;
    assign fft_start    = r_fft_start;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_m_fft_load_ctrl.sv
// Randomized scoreboard bench for m_fft_load_ctrl: a bit-reversed and a
// natural-order instance receive the same stream and are checked every cycle.
module tb_m_fft_load_ctrl;
    localparam int AW      = 5;
    localparam int DW      = 16;
    localparam int N       = 1 << AW;
    localparam int NFRAMES = 262;
    localparam int BIG     = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fft_done = 1'b0;
    logic drv_valid = 1'b0;
    logic [DW-1:0] drv_data = '0;

    always #5 clk = ~clk;

    m_fft_load_ctrl_if #(.DATA_WIDTH(DW)) s_if_b ();
    m_fft_load_ctrl_if #(.DATA_WIDTH(DW)) s_if_n ();
    assign s_if_b.s_valid = drv_valid;
    assign s_if_b.s_data  = drv_data;
    assign s_if_n.s_valid = drv_valid;
    assign s_if_n.s_data  = drv_data;

    logic [AW-1:0] ram_addr_b, ram_addr_n;
    logic [DW-1:0] ram_data_b, ram_data_n;
    logic          ram_we_b, ram_we_n, fft_start_b, fft_start_n, busy_b, busy_n;
    logic [7:0]    frame_cnt_b, frame_cnt_n;

    m_fft_load_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BITREV(1)) dut_b (
        .clk(clk), .rst(rst), .s_if(s_if_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_we(ram_we_b),
        .fft_start(fft_start_b), .fft_done(fft_done), .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    m_fft_load_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BITREV(0)) dut_n (
        .clk(clk), .rst(rst), .s_if(s_if_n),
        .ram_addr(ram_addr_n), .ram_data(ram_data_n), .ram_we(ram_we_n),
        .fft_start(fft_start_n), .fft_done(fft_done), .busy(busy_n), .frame_cnt(frame_cnt_n)
    );

    typedef struct {
        int          cyc;
        int          a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t     wq_b[$];
    wr_t     wq_n[$];
    int      sq[$];
    logic [DW-1:0] frame_s[N];
    logic [DW-1:0] ram_model_b[N];
    logic [DW-1:0] ram_model_n[N];

    int  cyc = 0;
    logic rst_q = 1'b1;
    int  n_model = 0;
    bit  locked = 1'b0;
    int  busy_from = BIG;
    int  exp_frames = 0;
    int  starts_seen = 0;
    int  last_a = 0;
    logic [DW-1:0] last_d = '0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic int bitrev(input int n);
        int r = 0;
        for (int i = 0; i < AW; i++) r = r * 2 + ((n >> i) & 1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: frame progress, lock while the FFT owns the frame, expected writes/starts.
    always @(negedge clk) begin
        wr_t e;
        if (rst_q) begin
            chk("rst_ram_we", ram_we_b, 0);
            chk("rst_ram_addr", ram_addr_b, 0);
            chk("rst_ram_data", ram_data_b, 0);
            chk("rst_fft_start", fft_start_b, 0);
            chk("rst_frame_cnt", frame_cnt_b, 0);
            chk("rst_busy", busy_b, 0);
            n_model   = 0;
            locked    = 1'b0;
            busy_from = BIG;
        end
        chk("s_ready_b", s_if_b.s_ready, !locked);
        chk("s_ready_n", s_if_n.s_ready, !locked);
        chk("busy_b", busy_b, locked);
        chk("busy_n", busy_n, locked);
        if (!rst) begin
            if (drv_valid && !locked) begin
                e.cyc = cyc + 1;
                e.d   = drv_data;
                e.a   = bitrev(n_model);
                wq_b.push_back(e);
                e.a   = n_model;
                wq_n.push_back(e);
                frame_s[n_model] = drv_data;
                if (n_model == N - 1) begin
                    n_model   = 0;
                    locked    = 1'b1;
                    sq.push_back(cyc + 3);
                    busy_from = cyc + 4;
                end else begin
                    n_model++;
                end
            end else if (locked && cyc >= busy_from && fft_done) begin
                locked    = 1'b0;
                busy_from = BIG;
            end
        end
    end

    // Monitor: pops expectations whenever the DUTs present writes or start pulses.
    always @(negedge clk) begin
        wr_t e;
        bit  exp_st;
        if (rst_q) begin
            exp_frames = 0;
            last_a     = 0;
            last_d     = '0;
        end
        if (wq_b.size() != 0 && wq_b[0].cyc == cyc) begin
            e = wq_b.pop_front();
            chk("ram_we_b", ram_we_b, 1);
            chk("ram_addr_b", ram_addr_b, e.a);
            chk("ram_data_b", ram_data_b, e.d);
            if (ram_we_b === 1'b1) ram_model_b[ram_addr_b] = ram_data_b;
            last_a = e.a;
            last_d = e.d;
        end else begin
            chk("ram_we_idle_b", ram_we_b, 0);
            chk("ram_addr_hold_b", ram_addr_b, last_a);
            chk("ram_data_hold_b", ram_data_b, last_d);
        end
        if (wq_n.size() != 0 && wq_n[0].cyc == cyc) begin
            e = wq_n.pop_front();
            chk("ram_we_n", ram_we_n, 1);
            chk("ram_addr_n", ram_addr_n, e.a);
            chk("ram_data_n", ram_data_n, e.d);
            if (ram_we_n === 1'b1) ram_model_n[ram_addr_n] = ram_data_n;
        end else begin
            chk("ram_we_idle_n", ram_we_n, 0);
        end
        exp_st = (sq.size() != 0 && sq[0] == cyc);
        chk("fft_start_b", fft_start_b, exp_st);
        chk("fft_start_n", fft_start_n, exp_st);
        chk("frame_cnt_b", frame_cnt_b, exp_frames);
        chk("frame_cnt_n", frame_cnt_n, exp_frames);
        if (exp_st) begin
            void'(sq.pop_front());
            for (int k = 0; k < N; k++) begin
                chk("regfile_b", ram_model_b[k], frame_s[bitrev(k)]);
                chk("regfile_n", ram_model_n[k], frame_s[k]);
            end
            $display("frame %0d start at cycle %0d frame_cnt %0d", starts_seen, cyc, frame_cnt_b);
            exp_frames = (exp_frames + 1) % 256;
            starts_seen++;
        end
    end

    // Stimulus: frame 0 streams n, frames 1-4 exercise gaps, back-pressure,
    // spurious done and mid-frame reset; the rest run at minimum frame period.
    initial begin
        int  st0;
        int  budget;
        int  hold;
        bit  fast;
        bit  did_reset;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int f = 0; f < NFRAMES; f++) begin
            fast      = (f >= 5) && (f % 16 != 7);
            did_reset = 1'b0;
            st0       = starts_seen;
            budget    = 0;
            while (starts_seen == st0) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
                budget++;
                if (budget > 4000) begin
                    errors++;
                    $display("FAIL timeout frame=%0d act_starts=%0d exp_starts=%0d", f, starts_seen, st0 + 1);
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $fatal(1, "timeout");
                end
                if (f == 3 && !did_reset && !locked && n_model == 17) begin
                    rst       = 1'b1;
                    drv_valid = 1'b0;
                    fft_done  = 1'b0;
                    did_reset = 1'b1;
                end else begin
                    if (f == 0 || f == 2 || fast) drv_valid = 1'b1;
                    else drv_valid = ($urandom_range(0, 2) != 0);
                    drv_data = (f == 0) ? DW'(n_model) : DW'($urandom);
                    if (locked && cyc >= busy_from) fft_done = fast;
                    else if (f == 3 && !locked && n_model == 10) fft_done = 1'b1;
                    else fft_done = (!fast && f != 2 && $urandom_range(0, 7) == 0);
                end
            end
            if (!fast) begin
                hold = (f == 2) ? 20 : int'($urandom_range(0, 6));
                repeat (hold) begin
                    @(posedge clk);
                    #1;
                    fft_done  = 1'b0;
                    drv_valid = (f == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    drv_data  = DW'($urandom);
                end
                @(posedge clk);
                #1;
                fft_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        fft_done  = 1'b0;
        drv_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("queues_drained", wq_b.size() + wq_n.size() + sq.size(), 0);
        chk("frames_started", starts_seen, NFRAMES);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
